// File: rtl/adaptive_perceptron.sv
// Online-trainable perceptron: N_IN signed weights plus bias, serial accumulate, saturating learning rule.
// Latency: vector accepted at edge k -> pred_valid in cycle k+N_IN+1; one extra cycle when a weight update follows.
// Backpressure: in_ready only in IDLE; in_valid and weight writes outside IDLE are ignored (source must hold).
module adaptive_perceptron #(
  parameter int N_IN      = 8,
  parameter int W_WIDTH   = 10,
  parameter int ACC_WIDTH = 16,
  parameter int INIT_W    = 80,
  parameter int INIT_BIAS = -304,
  parameter int LR        = 16,
  localparam int AW       = $clog2(N_IN + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_IN-1:0]           x,
  input  logic                      train,
  input  logic                      label,
  output logic                      pred_valid,
  output logic                      predict,
  input  logic                      w_wr_en,
  input  logic [AW-1:0]             w_wr_addr,
  input  logic signed [W_WIDTH-1:0] w_wr_data,
  output logic                      busy
);

  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic signed [W_WIDTH:0] SAT_MAX = (W_WIDTH+1)'((2 ** (W_WIDTH-1)) - 1);
  localparam logic signed [W_WIDTH:0] SAT_MIN = (W_WIDTH+1)'(-(2 ** (W_WIDTH-1)));
  localparam logic signed [W_WIDTH:0] STEP    = (W_WIDTH+1)'(LR);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DECIDE, S_UPDATE} state_t;

  state_t                      state_q;
  logic signed [W_WIDTH-1:0]   w_q [N_IN];
  logic signed [W_WIDTH-1:0]   bias_q;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_d;
  logic [IW-1:0]               idx_q;
  logic [N_IN-1:0]             x_q;
  logic                        train_q;
  logic                        label_q;
  logic                        pred_valid_q;
  logic                        predict_q;
  logic signed [W_WIDTH-1:0]   w_upd [N_IN];
  logic signed [W_WIDTH-1:0]   bias_upd;
  logic                        wr_bias;

  // One learning step (+LR toward class 1, -LR toward class 0), clamped instead of wrapping.
  function automatic logic signed [W_WIDTH-1:0] sat_step(input logic signed [W_WIDTH-1:0] w,
                                                         input logic up);
    logic signed [W_WIDTH:0] s;
    s = up ? ((W_WIDTH+1)'(w) + STEP) : ((W_WIDTH+1)'(w) - STEP);
    if (s > SAT_MAX) begin
      return SAT_MAX[W_WIDTH-1:0];
    end else if (s < SAT_MIN) begin
      return SAT_MIN[W_WIDTH-1:0];
    end else begin
      return s[W_WIDTH-1:0];
    end
  endfunction

  assign wr_bias    = w_wr_en && (w_wr_addr == AW'(N_IN));
  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign pred_valid = pred_valid_q;
  assign predict    = predict_q;

  // Next accumulator value: add the current weight when its feature bit is set.
  always_comb begin
    acc_d = acc_q;
    if (x_q[idx_q]) begin
      acc_d = acc_q + ACC_WIDTH'(w_q[idx_q]);
    end
  end

  // Candidate post-training values for every weight and the bias, computed in parallel.
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      w_upd[i] = sat_step(w_q[i], label_q);
    end
    bias_upd = sat_step(bias_q, label_q);
  end

  // Control FSM with weight storage, accumulator and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < N_IN; i++) begin
        w_q[i] <= W_WIDTH'(INIT_W);
      end
      bias_q       <= W_WIDTH'(INIT_BIAS);
      acc_q        <= '0;
      idx_q        <= '0;
      x_q          <= '0;
      train_q      <= 1'b0;
      label_q      <= 1'b0;
      pred_valid_q <= 1'b0;
      predict_q    <= 1'b0;
    end else begin
      pred_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_wr_en) begin
            for (int i = 0; i < N_IN; i++) begin
              if (w_wr_addr == AW'(i)) begin
                w_q[i] <= w_wr_data;
              end
            end
          end
          if (wr_bias) begin
            bias_q <= w_wr_data;
          end
          if (in_valid) begin
            x_q     <= x;
            train_q <= train;
            label_q <= label;
            // A same-edge bias write must seed the sum, so bypass the old register.
            acc_q   <= wr_bias ? ACC_WIDTH'(w_wr_data) : ACC_WIDTH'(bias_q);
            idx_q   <= '0;
            state_q <= S_ACC;
          end
        end
        S_ACC: begin
          acc_q <= acc_d;
          if (idx_q == IW'(N_IN - 1)) begin
            // Decision is registered here so predict and pred_valid appear together in DECIDE.
            pred_valid_q <= 1'b1;
            predict_q    <= ~acc_d[ACC_WIDTH-1];
            state_q      <= S_DECIDE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_DECIDE: begin
          if (train_q && (predict_q != label_q)) begin
            state_q <= S_UPDATE;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_UPDATE: begin
          for (int i = 0; i < N_IN; i++) begin
            if (x_q[i]) begin
              w_q[i] <= w_upd[i];
            end
          end
          bias_q  <= bias_upd;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adaptive_perceptron.sv
// Bench for adaptive_perceptron: directed scenarios plus randomized traffic against a behavioural model.
// The model works per transaction (sum, decision, update) and a busy-cycle countdown.
// A compare process checks busy/in_ready/pred_valid/predict every cycle outside reset.
module tb_adaptive_perceptron;

  localparam int N_IN      = 8;
  localparam int W_WIDTH   = 10;
  localparam int INIT_W    = 80;
  localparam int INIT_BIAS = -304;
  localparam int LR        = 16;
  localparam int AW        = 4;
  localparam int WMAX      = 511;
  localparam int WMIN      = -512;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic [N_IN-1:0]           x = '0;
  logic                      train = 1'b0;
  logic                      label = 1'b0;
  logic                      pred_valid;
  logic                      predict;
  logic                      w_wr_en = 1'b0;
  logic [AW-1:0]             w_wr_addr = '0;
  logic signed [W_WIDTH-1:0] w_wr_data = '0;
  logic                      busy;

  always #5 clk = ~clk;

  adaptive_perceptron dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x          (x),
    .train      (train),
    .label      (label),
    .pred_valid (pred_valid),
    .predict    (predict),
    .w_wr_en    (w_wr_en),
    .w_wr_addr  (w_wr_addr),
    .w_wr_data  (w_wr_data),
    .busy       (busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int mw [N_IN];
  int mbias;
  int m_cnt;
  int m_sum;
  bit m_upd;
  bit m_pred_new;
  bit m_shown;

  function automatic int sat(input int v);
    if (v > WMAX) return WMAX;
    if (v < WMIN) return WMIN;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_IN; i++) mw[i] = INIT_W;
    mbias = INIT_BIAS;
    m_cnt = 0;
    m_upd = 1'b0;
    m_sum = 0;
    m_pred_new = 1'b0;
  endtask

  initial begin
    int sum;
    int step;
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else if (m_cnt == 0) begin
        if (w_wr_en && (int'(w_wr_addr) <= N_IN)) begin
          if (int'(w_wr_addr) == N_IN) mbias = int'(w_wr_data);
          else mw[int'(w_wr_addr)] = int'(w_wr_data);
        end
        if (in_valid) begin
          sum = mbias;
          for (int i = 0; i < N_IN; i++) if (x[i]) sum += mw[i];
          m_sum      = sum;
          m_pred_new = (sum >= 0);
          m_upd      = train && (m_pred_new != label);
          if (m_upd) begin
            step = label ? LR : -LR;
            for (int i = 0; i < N_IN; i++) if (x[i]) mw[i] = sat(mw[i] + step);
            mbias = sat(mbias + step);
          end
          m_cnt = N_IN + 1 + (m_upd ? 1 : 0);
        end
      end else begin
        m_cnt--;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    bit exp_busy;
    bit exp_pv;
    m_shown = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        m_shown = 1'b0;
      end else begin
        exp_busy = (m_cnt > 0);
        exp_pv   = (m_cnt > 0) && (m_cnt == (m_upd ? 2 : 1));
        if (exp_pv) m_shown = m_pred_new;
        chk("busy", int'(busy), int'(exp_busy));
        chk("in_ready", int'(in_ready), int'(!exp_busy));
        chk("pred_valid", int'(pred_valid), int'(exp_pv));
        chk("predict", int'(predict), int'(m_shown));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready();
    int g = 0;
    @(negedge clk);
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) chk("ready_timeout", 0, 1);
  endtask

  task automatic wait_pred(inout int lat, output bit pred);
    while (!pred_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 30) chk("pred_timeout", 0, 1);
    pred = predict;
  endtask

  task automatic send_wait(input logic [N_IN-1:0] xv, input bit tr, input bit lb,
                           output bit pred, output int lat);
    wait_ready();
    in_valid = 1'b1;
    x = xv;
    train = tr;
    label = lb;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    wait_pred(lat, pred);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic signed [W_WIDTH-1:0] d);
    wait_ready();
    w_wr_en = 1'b1;
    w_wr_addr = a;
    w_wr_data = d;
    @(negedge clk);
    w_wr_en = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit p;
    int lat;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_predict", int'(predict), 0);

    // All features set: 8*80 - 304 = 336 -> class 1, nine cycles after acceptance.
    send_wait(8'hFF, 1'b0, 1'b0, p, lat);
    chk("t1_latency", lat, 9);
    chk("t1_predict", int'(p), 1);
    chk("t1_model_sum", m_sum, 336);

    // 3*80 - 304 = -64 -> class 0.
    send_wait(8'h07, 1'b0, 1'b0, p, lat);
    chk("t2_predict", int'(p), 0);
    chk("t2_model_sum", m_sum, -64);

    // Training toward class 1 moves w0..w2 to 96 and bias to -288; resubmit lands exactly on zero.
    send_wait(8'h07, 1'b1, 1'b1, p, lat);
    chk("t3_predict", int'(p), 0);
    chk("t3_model_w0", mw[0], 96);
    chk("t3_model_w3", mw[3], 80);
    chk("t3_model_bias", mbias, -288);
    send_wait(8'h07, 1'b0, 1'b0, p, lat);
    chk("t3_zero_sum", m_sum, 0);
    chk("t3_zero_predict", int'(p), 1);

    // Writes during ACC, in_valid while busy and an out-of-range address all leave state alone.
    pulse_reset();
    wait_ready();
    in_valid = 1'b1;
    x = 8'hFF;
    train = 1'b0;
    label = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    x = 8'h00;
    train = 1'b1;
    w_wr_en = 1'b1;
    w_wr_addr = 4'd0;
    w_wr_data = 10'sd0;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    w_wr_en = 1'b0;
    lat = 4;
    wait_pred(lat, p);
    chk("t5_busy_predict", int'(p), 1);
    chk("t5_busy_sum", m_sum, 336);
    do_write(4'd9, -10'sd512);
    send_wait(8'hFF, 1'b0, 1'b0, p, lat);
    chk("t5_addr9_predict", int'(p), 1);
    chk("t5_addr9_sum", m_sum, 336);

    // Saturation: 500 + 16 clamps to 511, bias -512 + 16 = -496.
    do_write(4'd0, 10'sd500);
    do_write(4'd8, -10'sd512);
    send_wait(8'h01, 1'b1, 1'b1, p, lat);
    chk("t4_predict", int'(p), 0);
    chk("t4_model_sum", m_sum, -12);
    chk("t4_model_w0_sat", mw[0], 511);
    chk("t4_model_bias", mbias, -496);

    // Reset in the 4th ACC cycle of a training vector aborts it and restores initial weights.
    wait_ready();
    in_valid = 1'b1;
    x = 8'hFF;
    train = 1'b1;
    label = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_pv_in_reset", int'(pred_valid), 0);
    end
    rst = 1'b0;
    send_wait(8'h07, 1'b0, 1'b0, p, lat);
    chk("t6_after_reset_predict", int'(p), 0);
    chk("t6_after_reset_sum", m_sum, -64);

    // Randomized traffic: overlapping writes/acceptances, busy-time noise, occasional resets.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 799) == 0);
      in_valid  = 1'($urandom);
      x         = 8'($urandom);
      train     = 1'($urandom);
      label     = 1'($urandom);
      w_wr_en   = ($urandom_range(0, 3) == 0);
      w_wr_addr = 4'($urandom_range(0, 10));
      w_wr_data = 10'($urandom);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    w_wr_en = 1'b0;
    repeat (15) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adaptive_perceptron.md
Name: adaptive_perceptron

Overview:
- Parametrised, clocked successor to the fixed-weight combinational perceptron.
- Holds N_IN signed weights plus a bias in registers and evaluates one input vector at a time by serial accumulation.
- Optionally applies the perceptron learning rule online, with saturating weights.
- Sits in the adaptive low-power predictor path. Weights are host-writable, so the classifier can be retuned without resynthesis.

Parameters:
- N_IN, 8, number of binary inputs / weights.
- W_WIDTH, 10, signed width of each weight and of the bias.
- ACC_WIDTH, 16, signed accumulator width; must be >= W_WIDTH + clog2(N_IN+1).
- INIT_W, 80, reset value of every weight.
- INIT_BIAS, -304, reset value of the bias.
- LR, 16, learning-rate step added to or subtracted from a weight on update.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input vector present.
- in_ready  out  1  block can accept a vector (high only in IDLE).
- x  in  N_IN  binary feature vector.
- train  in  1  sampled with x; enables learning for this vector.
- label  in  1  sampled with x; target class for training.
- pred_valid  out  1  one-cycle pulse, predict is valid.
- predict  out  1  classification result, held until the next pred_valid.
- w_wr_en  in  1  weight write strobe.
- w_wr_addr  in  clog2(N_IN+1)  0..N_IN-1 select a weight; N_IN selects the bias.
- w_wr_data  in  W_WIDTH  signed write value.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, all weights=INIT_W, bias=INIT_BIAS, accumulator=0, index=0.
  - Captured x, train and label registers cleared.
  - pred_valid=0, predict=0, in_ready=1 once rst deasserts, busy=0.
- States: IDLE -> ACC -> DECIDE -> (UPDATE) -> IDLE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture x/train/label, load accumulator with sign-extended bias, set index=0, go to ACC.
- ACC:
  - Exactly N_IN cycles.
  - Each cycle: if x_cap[index]=1, accumulator += sign-extended w[index]; then index++.
  - Leave to DECIDE after index N_IN-1.
- DECIDE:
  - One cycle, pred_valid=1, predict=(acc>=0). Zero counts as class 1.
  - If train_cap=1 and predict!=label_cap, go to UPDATE; else go to IDLE.
- UPDATE:
  - One cycle. For every i with x_cap[i]=1: w[i] += LR if label_cap=1, else w[i] -= LR.
  - Bias is updated the same way unconditionally.
  - All updates are in parallel.
  - Results saturate to [-2^(W_WIDTH-1), 2^(W_WIDTH-1)-1]; no wrap-around.
  - Then go to IDLE.
- Latency: vector accepted at edge k -> pred_valid high in cycle k+N_IN+1.
  - Next acceptance is possible at the edge ending that cycle (no update) or one cycle later (update).
- in_valid outside IDLE is ignored: no capture, no queueing. The source must hold until in_ready.
- Weight writes:
  - Take effect only in IDLE.
  - w_wr_en outside IDLE is ignored.
  - w_wr_addr > N_IN is ignored.
  - A write and an acceptance on the same IDLE edge are both performed. The written value is used by the computation; a bias write loads the accumulator with the new bias.
- The predict register updates only in DECIDE; pred_valid is never asserted outside DECIDE.
- Reset mid-operation (ACC/DECIDE/UPDATE) aborts immediately: no pred_valid, partial updates discarded, weights return to INIT.

Test Plan:
- Reset, x=8'hFF, train=0 -> sum 640-304=336; pred_valid exactly 9 cycles after acceptance, predict=1; in_ready=0 for the 9 busy cycles.
- x=8'h07, train=0 -> sum -64 -> predict=0; weights unchanged; in_ready returns the cycle after DECIDE.
- x=8'h07, train=1, label=1 -> predict=0, UPDATE: w0..w2=96, bias=-288, w3..w7=80. Resubmit 8'h07 train=0 -> sum=0 -> predict=1 (zero boundary).
- Write w0=500 (addr 0), bias=-512 (addr 8). Then x=8'h01, train=1, label=1 -> sum -12, predict=0; after update w0=511 (saturated), bias=-496.
- Write pulses during ACC, addr 9, and in_valid while busy -> no weight change, no extra capture; a repeat 8'hFF still gives 336 -> predict=1.
- Assert rst in the 4th ACC cycle of a training vector -> no pred_valid; after release, 8'h07 gives predict=0 (weights back to 80/-304).
